// File: rtl/m_uart_wb_master_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone bridge.
package m_uart_wb_master_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
   localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_BUS,
      ST_RESP
   } wbm_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Baud counters run reload..0, so a period of div cycles reloads with div-1.
   function automatic logic [15:0] baud_reload(input int unsigned div);
      return 16'(div - 1);
   endfunction

endpackage

// File: rtl/m_uart_wb_master_if.sv
// Wishbone classic single-beat bus between the bridge (master) and a slave.
interface m_uart_wb_master_if;
   logic        CYC_O;
   logic        STB_O;
   logic        WE_O;
   logic [31:0] ADR_O;
   logic [31:0] DAT_O;
   logic [3:0]  SEL_O;
   logic        ACK_I;
   logic [31:0] DAT_I;

   modport master (
      output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
      input  ACK_I, DAT_I
   );

   modport slave (
      input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O,
      output ACK_I, DAT_I
   );
endinterface

// File: rtl/m_uart_wb_master_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit validation at half a bit,
// mid-bit data sampling LSB first, one-cycle rx_valid / rx_ferr pulses.
module m_uart_rx_byte
   import m_uart_wb_master_pkg::*;
#(
   parameter int unsigned CLKDIV = 104
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr
);

   localparam logic [15:0] FULL_RL = baud_reload(CLKDIV);
   localparam logic [15:0] HALF_RL = baud_reload(CLKDIV / 2);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        prev_q,  prev_d;
   rx_state_t   state_q, state_d;
   logic [15:0] cnt_q,   cnt_d;
   logic [2:0]  bit_q,   bit_d;
   logic [7:0]  sh_q,    sh_d;
   logic        valid_q, valid_d;
   logic        ferr_q,  ferr_d;

   // Next-state: synchroniser, edge detect and the bit-timing state machine.
   always_comb begin
      sync1_d = rx_i;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
               cnt_d   = HALF_RL;
            end
         end
         RX_START: begin
            if (cnt_q == 16'd0) begin
               if (sync2_q) begin
                  state_d = RX_IDLE;          // glitch, not a start bit
               end else begin
                  state_d = RX_DATA;
                  cnt_d   = FULL_RL;
                  bit_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == 16'd0) begin
               sh_d  = {sync2_q, sh_q[7:1]};
               cnt_d = FULL_RL;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == 16'd0) begin
               valid_d = sync2_q;
               ferr_d  = !sync2_q;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // State registers; the line is assumed idle (high) out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 3'd0;
         sh_q    <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_data  = sh_q;
   assign rx_ferr  = ferr_q;

endmodule

// File: rtl/m_uart_wb_master.sv
// UART-to-Wishbone bridge: decodes 'W'/'R' command frames from the serial host,
// runs one single-beat Wishbone cycle and serialises the response back.
// Optional ACK watchdog enabled by defining UART_WBM_TIMEOUT_EN.
module m_uart_wb_master
   import m_uart_wb_master_pkg::*;
#(
   parameter int unsigned CLKDIV = 104,
   parameter int unsigned TOUT_W = 16
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic            usartRX,
   output logic            usartTX,
   output logic            busy,
   m_uart_wb_master_if.master wb
);

   localparam logic [15:0] FULL_RL = baud_reload(CLKDIV);

   // Out-of-range configurations leave this marker block in the hierarchy.
   if (CLKDIV < 8 || CLKDIV > 65535 || TOUT_W < 1 || TOUT_W > 31) begin : g_bad_cfg
   end

   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ferr;

   m_uart_rx_byte #(.CLKDIV(CLKDIV)) u_rx (
      .clk      (CLK_I),
      .rst      (RST_I),
      .rx_i     (usartRX),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ferr  (rx_ferr)
   );

   wbm_state_t  state_q;
   logic [1:0]  idx_q;
   logic        we_q;
   logic        cyc_q;
   logic        stb_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [31:0] resp_q;
   logic [2:0]  left_q;
   logic        busy_q;
`ifdef UART_WBM_TIMEOUT_EN
   logic [TOUT_W-1:0] wd_q;
`endif

   logic [9:0]  tx_sh_q,  tx_sh_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]  tx_bit_q, tx_bit_d;
   logic        tx_act_q, tx_act_d;
   logic        tx_last;
   logic        tx_ld;

   // Last cycle of a stop bit; a pending byte loads here so there is no gap.
   assign tx_last = tx_act_q && (tx_cnt_q == 16'd0) && (tx_bit_q == 4'd9);
   assign tx_ld   = (state_q == ST_RESP) && (left_q != 3'd0) && (!tx_act_q || tx_last);

   // Command FSM: frame decode, bus cycle, response sequencing.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         resp_q  <= 32'd0;
         left_q  <= 3'd0;
         busy_q  <= 1'b0;
`ifdef UART_WBM_TIMEOUT_EN
         wd_q    <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
`ifdef UART_WBM_TIMEOUT_EN
               wd_q <= '0;
`endif
               if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                  we_q    <= (rx_data == CMD_WR);
                  idx_q   <= 2'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (rx_ferr) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (rx_valid) begin
                  adr_q[{idx_q, 3'b000} +: 8] <= rx_data;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     if (we_q) begin
                        state_q <= ST_WDATA;
                     end else begin
                        state_q <= ST_BUS;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (rx_ferr) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (rx_valid) begin
                  dat_q[{idx_q, 3'b000} +: 8] <= rx_data;
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q <= ST_BUS;
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                  end
               end
            end
            ST_BUS: begin
               if (wb.ACK_I) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= ST_RESP;
                  if (we_q) begin
                     resp_q <= {24'd0, RSP_ACK};
                     left_q <= 3'd1;
                  end else begin
                     resp_q <= wb.DAT_I;
                     left_q <= 3'd4;
                  end
               end
`ifdef UART_WBM_TIMEOUT_EN
               else if (wd_q == {TOUT_W{1'b1}}) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  state_q <= ST_RESP;
                  resp_q  <= {24'd0, RSP_NAK};
                  left_q  <= 3'd1;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               if (tx_ld) begin
                  resp_q <= {8'd0, resp_q[31:8]};
                  left_q <= left_q - 3'd1;
               end else if (tx_last && left_q == 3'd0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // TX serialiser next-state: start bit, 8 data bits LSB first, stop bit.
   always_comb begin
      tx_sh_d  = tx_sh_q;
      tx_cnt_d = tx_cnt_q;
      tx_bit_d = tx_bit_q;
      tx_act_d = tx_act_q;
      if (tx_ld) begin
         tx_sh_d  = {1'b1, resp_q[7:0], 1'b0};
         tx_cnt_d = FULL_RL;
         tx_bit_d = 4'd0;
         tx_act_d = 1'b1;
      end else if (tx_act_q) begin
         if (tx_cnt_q == 16'd0) begin
            if (tx_bit_q == 4'd9) begin
               tx_act_d = 1'b0;
               tx_sh_d  = '1;
            end else begin
               tx_sh_d  = {1'b1, tx_sh_q[9:1]};
               tx_cnt_d = FULL_RL;
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end else begin
            tx_cnt_d = tx_cnt_q - 16'd1;
         end
      end
   end

   // TX registers; reset drives the line back to idle high immediately.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         tx_sh_q  <= '1;
         tx_cnt_q <= 16'd0;
         tx_bit_q <= 4'd0;
         tx_act_q <= 1'b0;
      end else begin
         tx_sh_q  <= tx_sh_d;
         tx_cnt_q <= tx_cnt_d;
         tx_bit_q <= tx_bit_d;
         tx_act_q <= tx_act_d;
      end
   end

   assign usartTX  = tx_sh_q[0];
   assign busy     = busy_q;
   assign wb.CYC_O = cyc_q;
   assign wb.STB_O = stb_q;
   assign wb.WE_O  = we_q & cyc_q;
   assign wb.ADR_O = adr_q;
   assign wb.DAT_O = dat_q;
   assign wb.SEL_O = 4'hF;

endmodule
